seg7_count_scan: RTL

SEG7_COUNT_SCAN -- requirements
Module: seg7_count_scan

---
 rtl/seg7_count_scan.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/seg7_count_scan.sv
// Four-digit BCD step counter driving a multiplexed, active-low 7-segment display.
// Ports:
//   clk     - system clock, rising edge
//   rst     - asynchronous active-low reset
//   step_in - asynchronous slow square wave; each rising edge requests one increment
//   en      - count enable (increments arriving while low are dropped)
//   clr     - synchronous clear, wins over a simultaneous increment
//   an      - active-low one-hot digit anodes, an[0] = rightmost digit
//   seg     - active-low cathodes, seg[0] = a .. seg[6] = g
//   dp      - active-low decimal point, held off
module seg7_count_scan #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLANK_LZ    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step_in,
  input  logic       en,
  input  logic       clr,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);

  logic            r_s1;
  logic            r_s2;
  logic            r_s3;
  logic            w_inc;
  logic [3:0][3:0] r_d;
  logic [3:0][3:0] w_d_inc;
  logic [4:0]      w_carry;
  logic [3:0]      w_lz;
  logic [PW-1:0]   r_pre;
  logic [1:0]      r_sel;
  logic [3:0]      w_cur;
  logic            w_blank;
  logic [6:0]      w_seg;
  logic [3:0]      w_an;
  logic [3:0]      r_an;
  logic [6:0]      r_seg;
  logic            r_dp;

  // Synchronizer plus history flop; s3 resetting low means a high step_in at reset release counts once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= step_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_inc = r_s2 & ~r_s3;

  // Decimal ripple: a digit advances only when every lower digit is 9.
  assign w_carry[0] = 1'b1;
  assign w_carry[1] = w_carry[0] & (r_d[0] == 4'd9);
  assign w_carry[2] = w_carry[1] & (r_d[1] == 4'd9);
  assign w_carry[3] = w_carry[2] & (r_d[2] == 4'd9);
  assign w_carry[4] = w_carry[3] & (r_d[3] == 4'd9);

  always_comb begin
    w_d_inc = r_d;
    for (int i = 0; i < 4; i++) begin
      if (w_carry[i]) begin
        w_d_inc[i] = (r_d[i] == 4'd9) ? 4'd0 : r_d[i] + 4'd1;
      end
    end
  end

  // Count register; clear drops any coincident increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_d <= '0;
    end else if (clr) begin
      r_d <= '0;
    end else if (w_inc && en) begin
      r_d <= w_d_inc;
    end
  end

  // Refresh prescaler and digit select.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pre <= '0;
      r_sel <= 2'd0;
    end else if (r_pre == PRE_MAX) begin
      r_pre <= '0;
      r_sel <= r_sel + 2'd1;
    end else begin
      r_pre <= r_pre + PW'(1);
    end
  end

  // w_lz[k]: digit k and all digits above it are zero.
  assign w_lz[3] = (r_d[3] == 4'd0);
  assign w_lz[2] = w_lz[3] & (r_d[2] == 4'd0);
  assign w_lz[1] = w_lz[2] & (r_d[1] == 4'd0);
  assign w_lz[0] = w_lz[1] & (r_d[0] == 4'd0);

  assign w_cur   = r_d[r_sel];
  assign w_blank = (BLANK_LZ != 0) && (r_sel != 2'd0) && w_lz[r_sel];
  assign w_an    = ~(4'b0001 << r_sel);

  // Active-low BCD decoder, bit order g..a.
  always_comb begin
    w_seg = 7'b1111111;
    case (w_cur)
      4'd0:    w_seg = 7'b1000000;
      4'd1:    w_seg = 7'b1111001;
      4'd2:    w_seg = 7'b0100100;
      4'd3:    w_seg = 7'b0110000;
      4'd4:    w_seg = 7'b0011001;
      4'd5:    w_seg = 7'b0010010;
      4'd6:    w_seg = 7'b0000010;
      4'd7:    w_seg = 7'b1111000;
      4'd8:    w_seg = 7'b0000000;
      4'd9:    w_seg = 7'b0010000;
      default: w_seg = 7'b1111111;
    endcase
  end

  // Display outputs reload every cycle so count changes show one clock later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_an;
      r_seg <= w_blank ? 7'b1111111 : w_seg;
      r_dp  <= 1'b1;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule
